// File: rtl/tt_sweep_capture_pkg.sv
// Shared types and derived-width helpers for the truth-table sweep/capture block.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  // Number of truth-table rows for a given input count.
  function automatic int unsigned n_rows(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // Width of the output-index read port; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n_out);
    return (n_out <= 1) ? 1 : $clog2(n_out);
  endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Bundle of control, stimulus/response and readout signals for tt_sweep_capture.
interface tt_sweep_capture_if
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 8
);
  localparam int unsigned N_ROWS = n_rows(N_IN);
  localparam int unsigned IW     = idx_width(N_OUT);

  logic              start;
  logic              busy;
  logic              done;
  logic [N_IN-1:0]   dut_x;
  logic [N_OUT-1:0]  dut_f;
  logic              rd_en;
  logic [IW-1:0]     rd_idx;
  logic [N_ROWS-1:0] rd_data;
  logic              rd_valid;

  // master: the environment issuing requests and hosting the netlist under test
  modport master (
    output start, dut_f, rd_en, rd_idx,
    input  busy, done, dut_x, rd_data, rd_valid
  );

  modport slave (
    input  start, dut_f, rd_en, rd_idx,
    output busy, done, dut_x, rd_data, rd_valid
  );

endinterface

// File: rtl/tt_sweep_capture_store.sv
// Truth-table storage: one row per input vector, cleared on demand, read by output column.
module tt_store #(
  parameter int unsigned N_ROWS = 8,
  parameter int unsigned N_OUT  = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned IW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [N_OUT-1:0]  wdata,
  input  logic [IW-1:0]     col_idx,
  output logic [N_ROWS-1:0] col_data
);

  logic [N_OUT-1:0] rows [N_ROWS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < N_ROWS; r++) rows[r] <= '0;
    end else if (clr) begin
      for (int unsigned r = 0; r < N_ROWS; r++) rows[r] <= '0;
    end else if (we) begin
      rows[waddr] <= wdata;
    end
  end

  // Indices with no matching output fall through to an all-zero column.
  always_comb begin
    col_data = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (col_idx == IW'(k)) begin
        for (int unsigned m = 0; m < N_ROWS; m++) col_data[m] = rows[m][k];
      end
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps every input vector into a combinational netlist, records its outputs as a
// truth table and serves the table back one output column at a time.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN       = 3,
  parameter int unsigned N_OUT      = 8,
  parameter int unsigned SETTLE_CYC = 1
) (
  input logic             clk,
  input logic             rst,
  tt_sweep_capture_if.slave bus
);

  localparam int unsigned N_ROWS = n_rows(N_IN);
  localparam int unsigned IW     = idx_width(N_OUT);
  localparam int unsigned VW     = N_IN + 1;
  localparam int unsigned SW     = $clog2(SETTLE_CYC + 1);

  state_t            state, state_n;
  logic [VW-1:0]     vec;
  logic [SW-1:0]     settle;
  logic              accept;
  logic              last_vec;
  logic              settled;
  logic              busy;
  logic [N_ROWS-1:0] col_data;
  logic [N_ROWS-1:0] rd_data;
  logic              rd_valid;

  assign accept   = (state == IDLE) && bus.start;
  assign last_vec = (vec == VW'(N_ROWS - 1));
  assign settled  = (settle == SW'(SETTLE_CYC - 1));
  assign busy     = (state == SETTLE) || (state == CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = SETTLE;
      SETTLE:  if (settled) state_n = CAPTURE;
      CAPTURE: state_n = last_vec ? DONE : SETTLE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The settle counter may step one past its terminal value on the SETTLE->CAPTURE
  // edge; its width leaves room for that and CAPTURE zeroes it again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec    <= '0;
      settle <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            vec    <= '0;
            settle <= '0;
          end
        end
        SETTLE: settle <= settle + SW'(1);
        CAPTURE: begin
          settle <= '0;
          if (!last_vec) vec <= vec + VW'(1);
        end
        default: ;
      endcase
    end
  end

  tt_store #(
    .N_ROWS (N_ROWS),
    .N_OUT  (N_OUT),
    .AW     (N_IN),
    .IW     (IW)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .we       (state == CAPTURE),
    .waddr    (vec[N_IN-1:0]),
    .wdata    (bus.dut_f),
    .col_idx  (bus.rd_idx),
    .col_data (col_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (bus.rd_en && !busy) begin
      rd_data  <= col_data;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = (state == DONE);
  assign bus.dut_x    = busy ? vec[N_IN-1:0] : '0;
  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: two instances (default settle, and SETTLE_CYC=3 driving a
// netlist model with a two-cycle response delay), checked against randomized truth tables.
module tb_tt_sweep_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_sweep_capture_if #(.N_IN(3), .N_OUT(8)) b1 ();
  tt_sweep_capture_if #(.N_IN(3), .N_OUT(5)) b2 ();

  tt_sweep_capture #(.N_IN(3), .N_OUT(8), .SETTLE_CYC(1)) u1 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );
  tt_sweep_capture #(.N_IN(3), .N_OUT(5), .SETTLE_CYC(3)) u2 (
    .clk (clk), .rst (rst), .bus (b2.slave)
  );

  // Truth tables as minterm-mask columns: bit m of tbl[k] is fk at x == m.
  logic [7:0] tbl1 [8];
  logic [7:0] tbl2 [5];

  // Netlist model 1: fixed functions on f0,f1,f2,f6, random tables elsewhere.
  always_comb begin
    b1.dut_f = '0;
    for (int k = 0; k < 8; k++) b1.dut_f[k] = tbl1[k][b1.dut_x];
    b1.dut_f[0] = b1.dut_x[0] & ~b1.dut_x[1] & b1.dut_x[2];
    b1.dut_f[1] = b1.dut_x[0] & b1.dut_x[1] & ~b1.dut_x[2];
    b1.dut_f[2] = (~b1.dut_x[0] & ~b1.dut_x[1] & ~b1.dut_x[2]) |
                  (b1.dut_x[0] & b1.dut_x[1] & b1.dut_x[2]);
    b1.dut_f[6] = b1.dut_x[1];
  end

  // Netlist model 2: random tables seen through a two-cycle pipeline.
  logic [4:0] f2_now, f2_d1, f2_d2;
  always_comb begin
    f2_now = '0;
    for (int k = 0; k < 5; k++) f2_now[k] = tbl2[k][b2.dut_x];
  end
  always_ff @(posedge clk) begin
    f2_d1 <= f2_now;
    f2_d2 <= f2_d1;
  end
  assign b2.dut_f = f2_d2;

  // Expected timeline relative to the accepting edge T, for cycle T+c.
  function automatic logic exp_busy(input int c, input int per);
    return (c >= 1) && (c <= 8 * per);
  endfunction
  function automatic logic [2:0] exp_x(input int c, input int per);
    return exp_busy(c, per) ? 3'((c - 1) / per) : 3'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (b1.busy !== 1'b0 || b1.done !== 1'b0 || b1.dut_x !== 3'd0 ||
        b1.rd_valid !== 1'b0 || b1.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_u1: busy=%b done=%b x=%0d rv=%b rd=%h want all 0",
               b1.busy, b1.done, b1.dut_x, b1.rd_valid, b1.rd_data);
    end
    checks++;
    if (b2.busy !== 1'b0 || b2.done !== 1'b0 || b2.dut_x !== 3'd0 ||
        b2.rd_valid !== 1'b0 || b2.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_u2: busy=%b done=%b x=%0d rv=%b rd=%h want all 0",
               b2.busy, b2.done, b2.dut_x, b2.rd_valid, b2.rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep_timing();
    int busy_cnt = 0, done_cnt = 0;
    b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      checks++;
      if (b1.busy !== exp_busy(c, 2) || b1.done !== (c == 17) || b1.dut_x !== exp_x(c, 2)) begin
        errors++;
        $display("FAIL sweep1_c%0d: busy=%b done=%b x=%0d want busy=%b done=%b x=%0d",
                 c, b1.busy, b1.done, b1.dut_x, exp_busy(c, 2), (c == 17), exp_x(c, 2));
      end
      if (b1.busy === 1'b1) busy_cnt++;
      if (b1.done === 1'b1) done_cnt++;
    end
    checks++;
    if (busy_cnt != 16 || done_cnt != 1) begin
      errors++;
      $display("FAIL sweep1_len: busy=%0d done=%0d cycles want 16 and 1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_readout();
    for (int k = 0; k < 8; k++) begin
      b1.rd_en  = 1'b1;
      b1.rd_idx = 3'(k);
      @(negedge clk);
      b1.rd_en = 1'b0;
      checks++;
      if (b1.rd_valid !== 1'b1 || b1.rd_data !== tbl1[k]) begin
        errors++;
        $display("FAIL read1_idx%0d: rv=%b data=%h want rv=1 data=%h",
                 k, b1.rd_valid, b1.rd_data, tbl1[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [3];
    want[0] = 8'h20; want[1] = 8'h08; want[2] = 8'h81;
    b1.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b1.rd_idx = 3'(i);
      @(negedge clk);
      checks++;
      if (b1.rd_valid !== 1'b1 || b1.rd_data !== want[i]) begin
        errors++;
        $display("FAIL b2b_idx%0d: rv=%b data=%h want rv=1 data=%h",
                 i, b1.rd_valid, b1.rd_data, want[i]);
      end
    end
    b1.rd_en = 1'b0;
    @(negedge clk);
    checks++;
    if (b1.rd_valid !== 1'b0 || b1.rd_data !== 8'h81) begin
      errors++;
      $display("FAIL b2b_hold: rv=%b data=%h want rv=0 data=81", b1.rd_valid, b1.rd_data);
    end
  endtask

  task automatic test_slow_settle();
    int done_at = -1;
    b2.start = 1'b1;
    @(posedge clk);
    #1 b2.start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      checks++;
      if (b2.busy !== exp_busy(c, 4) || b2.dut_x !== exp_x(c, 4)) begin
        errors++;
        $display("FAIL sweep2_c%0d: busy=%b x=%0d want busy=%b x=%0d",
                 c, b2.busy, b2.dut_x, exp_busy(c, 4), exp_x(c, 4));
      end
      if (b2.done === 1'b1 && done_at < 0) done_at = c;
    end
    checks++;
    if (done_at != 33) begin
      errors++;
      $display("FAIL sweep2_done: at T+%0d want T+33", done_at);
    end
    for (int k = 0; k < 8; k++) begin
      logic [7:0] want;
      want = (k < 5) ? tbl2[k] : 8'h00;
      b2.rd_en  = 1'b1;
      b2.rd_idx = 3'(k);
      @(negedge clk);
      b2.rd_en = 1'b0;
      checks++;
      if (b2.rd_valid !== 1'b1 || b2.rd_data !== want) begin
        errors++;
        $display("FAIL read2_idx%0d: rv=%b data=%h want rv=1 data=%h",
                 k, b2.rd_valid, b2.rd_data, want);
      end
    end
  endtask

  task automatic test_mid_sweep_start();
    b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      checks++;
      if (b1.busy !== exp_busy(c, 2) || b1.done !== (c == 17) || b1.dut_x !== exp_x(c, 2)) begin
        errors++;
        $display("FAIL midstart_c%0d: busy=%b done=%b x=%0d want busy=%b done=%b x=%0d",
                 c, b1.busy, b1.done, b1.dut_x, exp_busy(c, 2), (c == 17), exp_x(c, 2));
      end
      if (c == 8) begin
        checks++;
        if (b1.rd_valid !== 1'b0) begin
          errors++;
          $display("FAIL busy_read: rv=%b want 0", b1.rd_valid);
        end
      end
      b1.start = (c == 4);
      b1.rd_en = (c == 7);
    end
    b1.start = 1'b0;
    b1.rd_en = 1'b0;
    // Table from this sweep must match the model again.
    b1.rd_en = 1'b1;
    b1.rd_idx = 3'd6;
    @(negedge clk);
    b1.rd_en = 1'b0;
    checks++;
    if (b1.rd_valid !== 1'b1 || b1.rd_data !== 8'hCC) begin
      errors++;
      $display("FAIL read1_idx6_again: rv=%b data=%h want rv=1 data=cc", b1.rd_valid, b1.rd_data);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (b1.busy !== 1'b1 || b1.dut_x !== 3'd4) begin
      errors++;
      $display("FAIL pre_rst: busy=%b x=%0d want busy=1 x=4", b1.busy, b1.dut_x);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (b1.busy !== 1'b0 || b1.done !== 1'b0 || b1.dut_x !== 3'd0) begin
      errors++;
      $display("FAIL async_rst: busy=%b done=%b x=%0d want 0 0 0", b1.busy, b1.done, b1.dut_x);
    end
    @(negedge clk);
    rst = 1'b0;
    b1.rd_en  = 1'b1;
    b1.rd_idx = 3'd0;
    @(negedge clk);
    b1.rd_en = 1'b0;
    checks++;
    if (b1.rd_valid !== 1'b1 || b1.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL post_rst_read: rv=%b data=%h want rv=1 data=00", b1.rd_valid, b1.rd_data);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (b1.done !== 1'b0 || b1.busy !== 1'b0) begin
        errors++;
        $display("FAIL post_rst_idle_c%0d: busy=%b done=%b want 0 0", c, b1.busy, b1.done);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) tbl1[k] = 8'($urandom);
    tbl1[0] = 8'h20;
    tbl1[1] = 8'h08;
    tbl1[2] = 8'h81;
    tbl1[6] = 8'hCC;
    for (int k = 0; k < 5; k++) tbl2[k] = 8'($urandom);
    b1.start = 1'b0; b1.rd_en = 1'b0; b1.rd_idx = '0;
    b2.start = 1'b0; b2.rd_en = 1'b0; b2.rd_idx = '0;

    test_reset();
    test_sweep_timing();
    test_readout();
    test_back_to_back();
    test_slow_settle();
    test_mid_sweep_start();
    test_reset_mid_sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
